// File: rtl/serial_adder.sv
// Bit-serial add/subtract: one full-adder cell and a registered carry process
// the operands LSB-first, one bit per clock, with a one-cycle done pulse.

module single_bit_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             c_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             busy,
  output logic             done
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic             c_msb;
  logic [CNT_W-1:0] cnt;
  logic             cell_s;
  logic             cell_co;

  single_bit_adder u_cell (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c_in  (carry),
    .s     (cell_s),
    .c_out (cell_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      carry    <= 1'b0;
      c_msb    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Subtract is a + ~b + 1, so the carry seeds the two's-complement +1.
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : c_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sum   <= {cell_s, sum[WIDTH-1:1]};
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= cell_co;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 2))
            c_msb <= cell_co;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            c_out    <= cell_co;
            overflow <= c_msb ^ cell_co;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): vector table plus hand-written
// sequences for start-while-busy, reset mid-run and back-to-back operation.

module tb_serial_adder;
  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic         c_in;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .c_in     (c_in),
    .a        (a),
    .b        (b),
    .sum      (sum),
    .c_out    (c_out),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       cin;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Called just after a negedge with the DUT idle; returns just after a negedge.
  task automatic run_op(input string name, input logic [7:0] va, input logic [7:0] vb,
                        input logic vsub, input logic vcin,
                        input logic [7:0] es, input logic eco, input logic eov);
    int n;
    int busyc;
    bit seen;
    a = va; b = vb; sub = vsub; c_in = vcin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~va; b = ~vb; sub = ~vsub; c_in = ~vcin;
    busyc = 0;
    seen  = 1'b0;
    n     = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
      else if (busy) busyc++;
    end
    check({name, "_seen"}, 32'(seen), 32'd1);
    check({name, "_lat"}, n, W + 1);
    check({name, "_busy"}, busyc, W);
    check({name, "_sum"}, 32'(sum), 32'(es));
    check({name, "_cout"}, 32'(c_out), 32'(eco));
    check({name, "_ovf"}, 32'(overflow), 32'(eov));
    @(negedge clk);
    check({name, "_pulse"}, 32'(done), 32'd0);
    check({name, "_hold"}, 32'(sum), 32'(es));
  endtask

  initial begin
    int d1;
    int d2;
    int dcnt;
    int lowc;
    logic [7:0] s1;

    vecs[0]  = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1]  = '{8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[3]  = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[4]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[5]  = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[6]  = '{8'hC0, 8'hC0, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0};
    vecs[7]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[8]  = '{8'h01, 8'h01, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
    vecs[9]  = '{8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[10] = '{8'h7F, 8'hFF, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[11] = '{8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; sub = 1'b0; c_in = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(c_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin,
             vecs[i].s, vecs[i].co, vecs[i].ov);

    // Start while busy: new request in RUN cycle 3 must be dropped.
    a = 8'h12; b = 8'h34; sub = 1'b0; c_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    d1 = 0; dcnt = 0; s1 = '0;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (n == 3) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF; sub = 1'b1;
      end
      if (n == 4) start = 1'b0;
      if (done) begin
        dcnt++;
        if (d1 == 0) begin
          d1 = n;
          s1 = sum;
        end
      end
    end
    check("busy_start_dones", dcnt, 1);
    check("busy_start_lat", d1, W + 1);
    check("busy_start_sum", 32'(s1), 32'h46);

    // Reset mid-run: asserted during RUN cycle 4.
    a = 8'h0F; b = 8'h01; sub = 1'b0; c_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_cout", 32'(c_out), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    dcnt = 0;
    for (int n = 0; n < W + 4; n++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("mid_rst_quiet", dcnt, 0);
    run_op("after_rst", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);

    // Back-to-back: start held high across two operations.
    a = 8'h01; b = 8'h02; sub = 1'b0; c_in = 1'b0; start = 1'b1;
    d1 = 0; d2 = 0; lowc = 0; s1 = '0;
    for (int n = 1; n <= 40 && d2 == 0; n++) begin
      @(negedge clk);
      if (d1 != 0 && !busy && !done) lowc++;
      if (d1 != 0 && done) begin
        d2 = n;
        start = 1'b0;
      end
      if (d1 != 0 && done && n == d1) d2 = 0;
      if (done && d1 == 0) begin
        d1 = n;
        s1 = sum;
        lowc = 1;
      end
    end
    start = 1'b0;
    check("b2b_first_lat", d1, W + 1);
    check("b2b_gap", d2 - d1, W + 2);
    check("b2b_busy_low", lowc, 2);
    check("b2b_sum1", 32'(s1), 32'h03);
    check("b2b_sum2", 32'(sum), 32'h03);
    @(negedge clk);
    @(negedge clk);
    check("b2b_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
